keypad_encoder: RTL and testbench

Scans the 4x4 matrix keypad, debounces it, and produces the `keystrobe`/`keycode` pair consumed by the digit decoder and the other keycode consumers.
- Drives one column at a time and samples the synchronized rows.
- Rejects bounce and multi-key ghosts.
- Emits exactly one strobe per accepted press, with the 4-bit code of the key.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_encoder_row_synchronizer.sv | 24 ++
 rtl/keypad_encoder.sv | 181 ++++++++++++++++++
 tb/tb_keypad_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad encoder.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Indexed by {row index, col index}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    KEY_STAR, 4'h0, KEY_HASH, 4'hD
  };

  function automatic logic is_single(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_encoder_row_synchronizer.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module row_synchronizer (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_i,
  output logic [3:0] row_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 4'd0;
      sync_q <= 4'd0;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner with debounce and ghost rejection; emits one keystrobe per press.
// Optional auto-repeat while held is compiled in with KEYPAD_AUTOREPEAT_EN.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_DELAY = 400,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keystrobe,
  output logic [3:0] keycode,
  output logic       keyheld
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT);

  logic [3:0]    row_s;
  logic [DW-1:0] div_cnt_q;
  kp_state_t     state_q;
  logic [3:0]    col_q;
  logic [1:0]    row_idx_q;
  logic [CW-1:0] cnt_q;
  logic          keystrobe_q;
  logic [3:0]    keycode_q;
  logic          keyheld_q;

  row_synchronizer u_row_sync (
    .clk   (clk),
    .nrst  (nrst),
    .row_i (row),
    .row_o (row_s)
  );

  logic          sample;
  logic [CW-1:0] cnt_inc;
  logic          cnt_done;
  logic [1:0]    hit_row;
  logic [3:0]    hit_code;
  logic [3:0]    col_next;
  logic          row_match;

  assign sample    = (div_cnt_q == DIV_LAST);
  assign cnt_inc   = cnt_q + CW'(1);
  assign cnt_done  = (cnt_inc == CNT_LAST);
  // A SCAN hit uses the live rows; DEBOUNCE uses the latched row.
  assign hit_row   = (state_q == SCAN) ? onehot_idx(row_s) : row_idx_q;
  assign hit_code  = KEY_MAP[{hit_row, onehot_idx(col_q)}];
  assign col_next  = {col_q[2:0], col_q[3]};
  assign row_match = (row_s == (4'd1 << row_idx_q));

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_L = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_L  = RW'(REPEAT_RATE);

  logic [RW-1:0] rep_cnt_q;
  logic          rep_armed_q;
  logic [RW-1:0] rep_inc;

  assign rep_inc = rep_cnt_q + RW'(1);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt_q <= '0;
    end else if (sample) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCAN;
      col_q       <= 4'b0001;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      keystrobe_q <= 1'b0;
      keycode_q   <= 4'h0;
      keyheld_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      keystrobe_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      // Any stay outside HELD restarts the repeat timing on the next entry.
      if (state_q != HELD) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end
`endif
      if (sample) begin
        case (state_q)
          SCAN: begin
            if (is_single(row_s)) begin
              row_idx_q <= onehot_idx(row_s);
              if (DEBOUNCE_CNT == 1) begin
                keystrobe_q <= 1'b1;
                keycode_q   <= hit_code;
                keyheld_q   <= 1'b1;
                state_q     <= HELD;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= DEBOUNCE;
              end
            end else begin
              col_q <= col_next;
            end
          end
          DEBOUNCE: begin
            if (row_match) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                keystrobe_q <= 1'b1;
                keycode_q   <= hit_code;
                keyheld_q   <= 1'b1;
                state_q     <= HELD;
              end
            end else begin
              col_q   <= col_next;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (row_s == 4'd0) begin
              if (DEBOUNCE_CNT == 1) begin
                keyheld_q <= 1'b0;
                col_q     <= col_next;
                state_q   <= SCAN;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= RELEASE;
              end
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_inc == (rep_armed_q ? RATE_L : DELAY_L)) begin
                keystrobe_q <= 1'b1;
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_inc;
              end
`endif
            end
          end
          RELEASE: begin
            if (row_s == 4'd0) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                keyheld_q <= 1'b0;
                col_q     <= col_next;
                state_q   <= SCAN;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign keystrobe = keystrobe_q;
  assign keycode   = keycode_q;
  assign keyheld   = keyheld_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench: a simulated 4x4 key matrix drives the encoder; expectations come
// from the key legend string and sample-level press/release rules.
module tb_keypad_encoder;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       keystrobe;
  logic [3:0] keycode;
  logic       keyheld;

  logic [15:0] keys = '0;
  int n_assert = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int tb_div = 0;
  string legend = "123A456B789C*0#D";

  always #5 clk = ~clk;

  // A pressed key at (r,c) connects column c to row r.
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
  end

  keypad_encoder #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .row       (row),
    .col       (col),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .keyheld   (keyheld)
  );

  always @(posedge clk or negedge nrst) begin
    if (!nrst) tb_div <= 0;
    else tb_div <= (tb_div == SD - 1) ? 0 : tb_div + 1;
  end

  always @(posedge clk) begin
    #1;
    if (nrst && keystrobe === 1'b1) strobe_cnt = strobe_cnt + 1;
  end

  function automatic int code_of(int idx);
    byte ch;
    ch = legend[idx];
    if (ch >= 48 && ch <= 57) return ch - 48;   // '0'..'9'
    if (ch >= 65 && ch <= 68) return ch - 55;   // 'A'..'D'
    if (ch == 42) return 14;                    // '*'
    return 15;                                  // '#'
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge right after the next sample edge.
  task automatic wait_sample();
    while (tb_div != SD - 1) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag, input int idx, input int budget, output int lat);
    int start;
    start = strobe_cnt;
    lat = 0;
    while (strobe_cnt == start && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_strobe"}, strobe_cnt - start, 1);
    if (strobe_cnt != start) begin
      check({tag, "_code"}, keycode, code_of(idx));
      check({tag, "_held"}, keyheld, 1);
      @(negedge clk);
      check({tag, "_width"}, keystrobe, 0);
    end
  endtask

  // Caller is aligned just after a sample; keyheld must drop on the DC-th zero sample.
  task automatic release_exact(input string tag, input int idx);
    int start;
    start = strobe_cnt;
    keys = '0;
    for (int n = 1; n <= DC; n++) begin
      wait_sample();
      check($sformatf("%s_rel%0d", tag, n), keyheld, (n < DC) ? 1 : 0);
    end
    check({tag, "_rel_nostrobe"}, strobe_cnt - start, 0);
    check({tag, "_rel_code"}, keycode, code_of(idx));
  endtask

  initial begin
    int lat;
    int start;
    int found;
    logic [3:0] prev_col;

    // Reset state and scan start
    repeat (2) @(negedge clk);
    check("rst_col", col, 4'b0001);
    check("rst_strobe", keystrobe, 0);
    check("rst_code", keycode, 0);
    check("rst_held", keyheld, 0);
    nrst = 1'b1;
    wait_sample();
    check("scan_col1", col, 4'b0010);
    wait_sample();
    check("scan_col2", col, 4'b0100);

    // Clean press of key 5, held without repeats, then release
    keys = 16'd1 << 5;
    wait_strobe("k5", 5, 60, lat);
    start = strobe_cnt;
    repeat (4) wait_sample();
    check("k5_no_extra", strobe_cnt - start, 0);
    check("k5_still_held", keyheld, 1);
    release_exact("k5", 5);

    // Bounce on key D: matching samples 1,1,0
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      wait_sample();
      if (col == 4'b0100) found = 1;
    end
    check("bnc_align", found, 1);
    start = strobe_cnt;
    keys = 16'd1 << 15;
    wait_sample();
    check("bnc_col_a", col, 4'b1000);
    wait_sample();
    check("bnc_col_b", col, 4'b1000);
    wait_sample();
    keys = '0;
    wait_sample();
    check("bnc_col_resume", col, 4'b0001);
    check("bnc_nostrobe", strobe_cnt - start, 0);
    check("bnc_noheld", keyheld, 0);
    keys = 16'd1 << 15;
    wait_strobe("kD", 15, 60, lat);
    wait_sample();
    release_exact("kD", 15);

    // Ghost: two rows in column 0
    start = strobe_cnt;
    keys = (16'd1 << 0) | (16'd1 << 8);
    wait_sample();
    for (int i = 0; i < 6; i++) begin
      prev_col = col;
      wait_sample();
      check($sformatf("ghost_rot%0d", i), col, {prev_col[2:0], prev_col[3]});
    end
    check("ghost_nostrobe", strobe_cnt - start, 0);
    keys = '0;
    wait_sample();

    // Release bounce on '*': rows 0,0,nonzero,0,0,0
    start = strobe_cnt;
    keys = 16'd1 << 12;
    wait_strobe("kS", 12, 60, lat);
    wait_sample();
    keys = '0;
    wait_sample();
    check("relb_s1", keyheld, 1);
    wait_sample();
    check("relb_s2", keyheld, 1);
    keys = 16'd1 << 12;
    wait_sample();
    check("relb_s3", keyheld, 1);
    release_exact("relb", 12);
    check("relb_total", strobe_cnt - start, 1);

    // Reset mid-press of '8', then full re-acceptance
    keys = 16'd1 << 9;
    wait_strobe("k8", 9, 60, lat);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mrst_col", col, 4'b0001);
    check("mrst_strobe", keystrobe, 0);
    check("mrst_code", keycode, 0);
    check("mrst_held", keyheld, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    wait_strobe("k8re", 9, 60, lat);
    check("k8re_latency", lat, 4 * SD);
    wait_sample();
    release_exact("k8re", 9);

    // Randomized presses and ghosts
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c, r1, r2;
        c = $urandom_range(0, 3);
        r1 = $urandom_range(0, 3);
        r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
        start = strobe_cnt;
        keys = '0;
        keys[r1*4 + c] = 1'b1;
        keys[r2*4 + c] = 1'b1;
        repeat (8) wait_sample();
        check($sformatf("rg%0d_nostrobe", it), strobe_cnt - start, 0);
        check($sformatf("rg%0d_noheld", it), keyheld, 0);
        keys = '0;
        wait_sample();
      end else begin
        int idx, hold;
        idx = $urandom_range(0, 15);
        hold = $urandom_range(1, 4);
        keys = 16'd1 << idx;
        wait_strobe($sformatf("rk%0d", it), idx, 60, lat);
        start = strobe_cnt;
        repeat (hold) wait_sample();
        check($sformatf("rk%0d_no_extra", it), strobe_cnt - start, 0);
        release_exact($sformatf("rk%0d", it), idx);
      end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat on key 0: repeats at held samples RD, RD+RR, RD+2*RR
    keys = 16'd1 << 13;
    wait_strobe("rep", 13, 60, lat);
    for (int n = 1; n <= RD + 2 * RR; n++) begin
      wait_sample();
      check($sformatf("rep_s%0d", n), keystrobe,
            (n >= RD && ((n - RD) % RR) == 0) ? 1 : 0);
      check($sformatf("rep_code%0d", n), keycode, 0);
    end
    release_exact("rep", 13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
